datapath_pipe: RTL and testbench
================================

# datapath_pipe

Parametrised two-stage successor to the 4-bit register-file/function-unit datapath. It holds NREG registers of WIDTH bits and decodes the same field-ordered control word. The word is read and muxed in stage 1 (RD), then computed and written back in stage 2 (EX). EX-to-RD forwarding gives back-to-back dependent words correct operands with no stalls, and registered V/C/N/Z status flags are added. It sits between the control sequencer (ControlWord, ConstantIn) and memory (AddressOut, DataOut, DataIn).

## Interface
- WIDTH, 4: datapath width in bits; must be >= 2.
- NREG, 4: number of registers; must be a power of 2 and >= 2. AW = log2(NREG).
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- Valid  in  1  ControlWord, ConstantIn and DataIn are valid this cycle.
- ControlWord  in  3*AW+7  fields from MSB to LSB: DA[AW], AA[AW], BA[AW], MB, FS[4], MD, RW. For NREG=4 this is DA[12:11] AA[10:9] BA[8:7] MB[6] FS[5:2] MD[1] RW[0].
- ConstantIn  in  WIDTH  constant operand, selected when MB=1.
- DataIn  in  WIDTH  memory data, selected for writeback when MD=1.
- AddressOut  out  WIDTH  forwarded A operand of the current word (combinational).
- DataOut  out  WIDTH  B-mux output of the current word (combinational).
- Status  out  4  registered {V,C,N,Z}.
- RegFlat  out  NREG*WIDTH  register contents; Rk occupies bits [k*WIDTH +: WIDTH].

## Operation
- **RD stage (combinational):**
  - A = R[AA], B = R[BA].
  - Forwarding: if the EX stage is valid with RW=1 and EX.DA equals AA (or BA), that operand takes the EX writeback value instead.
  - Bmux = MB ? ConstantIn : B.
  - AddressOut = A; DataOut = Bmux.
- **RD→EX register:** on each edge, latches A, Bmux, DataIn, DA, FS, MD, RW and Valid. A word with Valid=0 becomes a bubble: no write, no flag change.
- **EX stage:** computes F per FS using (WIDTH+1)-bit arithmetic.
  - 0000 A; 0001 A+1; 0010 A+B; 0011 A+B+1; 0100 A+~B; 0101 A+~B+1 (A−B); 0110 A−1; 0111 A.
  - 1000 A&B; 1001 B; 1010 A|B; 1011 B>>1 (logical); 1100 A^B; 1101 B<<1; 1110 ~A; 1111 zero.
- **Writeback:** WB = MD ? DataIn : F. If EX is valid and RW=1, R[DA] is written at the edge ending EX. R0 is an ordinary writable register.
- **Flags** update at that same edge, only when EX is valid and MD=0:
  - Z = (F==0); N = F[WIDTH−1].
  - Arithmetic codes (0000–0111): C = carry out of bit WIDTH−1; V = signed overflow. For A−1, C is taken from A+all-ones. For pass codes 0000/0111, C=V=0.
  - Logic codes: C=V=0, except 1011, where C = B[0], and 1101, where C = B[WIDTH−1].
  - When MD=1 or EX is invalid, Status holds.
- **Register file:** no read-during-write hazard beyond forwarding. The RD stage reads pre-edge contents, and forwarding covers the one in-flight word.

## Timing
- **Reset (RST=1, asynchronous):** all registers 0, EX Valid 0, Status 0. RegFlat=0 immediately. AddressOut and DataOut then reflect zero registers, or ConstantIn when MB=1.
- **Latency:** a word accepted at edge k is written to its register and updates Status at edge k+1.
- **Throughput:** one word per cycle, no stalls.
- **Reset mid-operation:** the in-flight EX word is discarded and not written. Words presented while RST=1 are ignored.
- **Simultaneous events:** if the EX word writes Rx while the RD word reads Rx as both A and B, both operands are forwarded. If the RD word also writes Rx, its own write lands one edge later and wins.
- **Wrap-around:** results are modulo 2^WIDTH; carry goes only to C.

## Test plan
- **Reset:** (WIDTH=4, NREG=4) load R1=5, then pulse RST asynchronously between edges -> RegFlat=0 and Status=0 before the next edge. The in-flight write to R1 never appears.
- **Constant load:** DA=1, MB=1, ConstantIn=5, FS=1001, MD=0, RW=1, Valid=1 at edge k -> RegFlat[7:4]=5 after edge k+1; Status=0000.
- **Forwarding:** the word above, immediately followed by DA=2, AA=1, BA=1, MB=0, FS=0010, RW=1 -> AddressOut=5 in the second cycle; R2=0xA; Status V=1 C=0 N=1 Z=0.
- **Subtract and zero:** R1=5, then DA=3, AA=1, BA=1, FS=0101 -> R3=0; Status V=0 C=1 N=0 Z=1.
- **Memory load and bubble:** MD=1, DataIn=0xC, DA=0, RW=1 -> R0=0xC with Status unchanged. A following Valid=0 word with RW=1 changes nothing.
- **Wrap and shift:** R1=0xF, FS=0001 -> result 0, C=1, Z=1. R1=0x9, FS=1101 with BA=1 -> result 0x2, C=1, N=0.

Source files
------------

// File: rtl/datapath_pipe.sv
// Two-stage register-file datapath: RD reads/forwards operands, EX computes F,
// writes back and updates the registered {V,C,N,Z} status.
module datapath_pipe #(
    parameter int WIDTH = 4,
    parameter int NREG  = 4
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        Valid,
    input  logic [3*$clog2(NREG)+6:0]   ControlWord,
    input  logic [WIDTH-1:0]            ConstantIn,
    input  logic [WIDTH-1:0]            DataIn,
    output logic [WIDTH-1:0]            AddressOut,
    output logic [WIDTH-1:0]            DataOut,
    output logic [3:0]                  Status,
    output logic [NREG*WIDTH-1:0]       RegFlat
);
    localparam int AW = $clog2(NREG);

    logic [AW-1:0]    da, aa, ba;
    logic             mb, md, rw;
    logic [3:0]       fs;

    assign rw = ControlWord[0];
    assign md = ControlWord[1];
    assign fs = ControlWord[5:2];
    assign mb = ControlWord[6];
    assign ba = ControlWord[7 +: AW];
    assign aa = ControlWord[7+AW +: AW];
    assign da = ControlWord[7+2*AW +: AW];

    logic [WIDTH-1:0] regs [NREG];

    logic             ex_valid, ex_md, ex_rw;
    logic [WIDTH-1:0] ex_a, ex_b, ex_din;
    logic [AW-1:0]    ex_da;
    logic [3:0]       ex_fs;

    logic [WIDTH-1:0] add_x, add_y;
    logic             add_cin;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH-1:0] f, wb, b_rd;
    logic             flag_c, flag_v, fwd;

    // All arithmetic codes share one adder; only the B-side operand and carry-in vary.
    always_comb begin
        add_x   = ex_a;
        add_y   = '0;
        add_cin = 1'b0;
        case (ex_fs)
            4'b0001: add_cin = 1'b1;
            4'b0010: add_y = ex_b;
            4'b0011: begin add_y = ex_b;  add_cin = 1'b1; end
            4'b0100: add_y = ~ex_b;
            4'b0101: begin add_y = ~ex_b; add_cin = 1'b1; end
            4'b0110: add_y = '1;
            default: ;
        endcase
    end

    assign add_sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};

    always_comb begin
        f      = '0;
        flag_c = 1'b0;
        flag_v = 1'b0;
        if (!ex_fs[3]) begin
            if (ex_fs == 4'b0000 || ex_fs == 4'b0111) begin
                f = ex_a;
            end else begin
                f      = add_sum[WIDTH-1:0];
                flag_c = add_sum[WIDTH];
                flag_v = (add_x[WIDTH-1] == add_y[WIDTH-1]) &&
                         (add_sum[WIDTH-1] != add_x[WIDTH-1]);
            end
        end else begin
            case (ex_fs[2:0])
                3'b000: f = ex_a & ex_b;
                3'b001: f = ex_b;
                3'b010: f = ex_a | ex_b;
                3'b011: begin f = {1'b0, ex_b[WIDTH-1:1]}; flag_c = ex_b[0]; end
                3'b100: f = ex_a ^ ex_b;
                3'b101: begin f = {ex_b[WIDTH-2:0], 1'b0}; flag_c = ex_b[WIDTH-1]; end
                3'b110: f = ~ex_a;
                default: f = '0;
            endcase
        end
    end

    assign wb  = ex_md ? ex_din : f;
    assign fwd = ex_valid && ex_rw;

    assign AddressOut = (fwd && ex_da == aa) ? wb : regs[aa];
    assign b_rd       = (fwd && ex_da == ba) ? wb : regs[ba];
    assign DataOut    = mb ? ConstantIn : b_rd;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ex_valid <= 1'b0;
            ex_md    <= 1'b0;
            ex_rw    <= 1'b0;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_din   <= '0;
            ex_da    <= '0;
            ex_fs    <= '0;
            Status   <= '0;
            for (int k = 0; k < NREG; k++) regs[k] <= '0;
        end else begin
            ex_valid <= Valid;
            ex_md    <= md;
            ex_rw    <= rw;
            ex_a     <= AddressOut;
            ex_b     <= DataOut;
            ex_din   <= DataIn;
            ex_da    <= da;
            ex_fs    <= fs;
            if (ex_valid && ex_rw)
                regs[ex_da] <= wb;
            if (ex_valid && !ex_md)
                Status <= {flag_v, flag_c, f[WIDTH-1], f == '0};
        end
    end

    for (genvar k = 0; k < NREG; k++) begin : g_flat
        assign RegFlat[k*WIDTH +: WIDTH] = regs[k];
    end

endmodule

// File: tb/tb_datapath_pipe.sv
// Bench for datapath_pipe: sequential-ISA reference model (words complete in order,
// visible state lags one edge) checked every negedge, plus literal spot checks.
module tb_datapath_pipe;
    localparam int W = 4;
    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          valid;
    logic [12:0]   cw;
    logic [W-1:0]  cst, din;
    logic [W-1:0]  addr, dout;
    logic [3:0]    status;
    logic [N*W-1:0] regflat;

    int compared = 0;
    int mismatched = 0;
    logic chk_en = 1'b0;

    datapath_pipe #(.WIDTH(W), .NREG(N)) dut (
        .CLK(clk), .RST(rst), .Valid(valid), .ControlWord(cw),
        .ConstantIn(cst), .DataIn(din), .AddressOut(addr), .DataOut(dout),
        .Status(status), .RegFlat(regflat)
    );

    always #5 clk = ~clk;

    // arch: every accepted word applied; vis: what the DUT must show (one word behind)
    logic [W-1:0] arch [N];
    logic [W-1:0] vis  [N];
    logic [3:0]   arch_st, vis_st;

    function automatic int sgn(input int x);
        return (x >= 2**(W-1)) ? x - 2**W : x;
    endfunction

    function automatic void add(input int x, input int y, input int cin,
                                output logic [W-1:0] f, output logic c, output logic v);
        int us, ss;
        us = x + y + cin;
        ss = sgn(x) + sgn(y) + cin;
        f  = W'(us % (2**W));
        c  = (us >= 2**W);
        v  = (ss > 2**(W-1) - 1) || (ss < -(2**(W-1)));
    endfunction

    task automatic apply_word();
        int a, b, ones;
        logic [W-1:0] f, res;
        logic c, v;
        a = int'(arch[cw[10:9]]);
        b = cw[6] ? int'(cst) : int'(arch[cw[8:7]]);
        ones = 2**W - 1;
        c = 1'b0; v = 1'b0; f = '0;
        case (cw[5:2])
            4'd0, 4'd7: f = W'(a);
            4'd1:  add(a, 0, 1, f, c, v);
            4'd2:  add(a, b, 0, f, c, v);
            4'd3:  add(a, b, 1, f, c, v);
            4'd4:  add(a, ones - b, 0, f, c, v);
            4'd5:  add(a, ones - b, 1, f, c, v);
            4'd6:  add(a, ones, 0, f, c, v);
            4'd8:  f = W'(a & b);
            4'd9:  f = W'(b);
            4'd10: f = W'(a | b);
            4'd11: begin f = W'(b / 2); c = (b % 2) != 0; end
            4'd12: f = W'(a ^ b);
            4'd13: begin f = W'((b * 2) % (2**W)); c = b >= 2**(W-1); end
            4'd14: f = W'(ones - a);
            default: f = '0;
        endcase
        res = cw[1] ? din : f;
        if (cw[0]) arch[cw[12:11]] = res;
        if (!cw[1]) arch_st = {v, c, f[W-1], f == 0};
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin arch[k] = '0; vis[k] = '0; end
            arch_st = '0; vis_st = '0;
        end else begin
            for (int k = 0; k < N; k++) vis[k] = arch[k];
            vis_st = arch_st;
            if (valid) apply_word();
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_addr", addr, arch[cw[10:9]]);
            check("model_data", dout, cw[6] ? cst : arch[cw[8:7]]);
            check("model_regs", regflat, {vis[3], vis[2], vis[1], vis[0]});
            check("model_status", status, vis_st);
        end
    end

    task automatic drive(input logic v, input logic [1:0] d, input logic [1:0] a,
                         input logic [1:0] b, input logic m, input logic [3:0] f,
                         input logic mdd, input logic rww, input logic [W-1:0] c,
                         input logic [W-1:0] di);
        valid = v;
        cw    = {d, a, b, m, f, mdd, rww};
        cst   = c;
        din   = di;
    endtask

    task automatic idle();
        drive(1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] d, input logic [W-1:0] c);
        drive(1'b1, d, 2'd0, 2'd0, 1'b1, 4'b1001, 1'b0, 1'b1, c, '0);
    endtask

    initial begin
        idle();
        #1 rst = 1'b1;
        #2;
        check("reset_regs", regflat, 16'h0);
        check("reset_status", status, 4'h0);
        #9 rst = 1'b0;
        chk_en = 1'b1;
        step();

        // constant load then dependent add with both operands forwarded
        load(2'd1, 4'h5);
        step();
        drive(1'b1, 2'd2, 2'd1, 2'd1, 1'b0, 4'b0010, 1'b0, 1'b1, '0, '0);
        #1;
        check("fwd_addr", addr, 4'h5);
        check("fwd_data", dout, 4'h5);
        step();
        check("const_r1", regflat[7:4], 4'h5);
        check("const_status", status, 4'b0000);
        idle();
        step();
        check("fwd_r2", regflat[11:8], 4'hA);
        check("fwd_status", status, 4'b1010);

        // subtract to zero
        drive(1'b1, 2'd3, 2'd1, 2'd1, 1'b0, 4'b0101, 1'b0, 1'b1, '0, '0);
        step(); idle(); step();
        check("sub_r3", regflat[15:12], 4'h0);
        check("sub_status", status, 4'b0101);

        // memory load, then a bubble that would zero R0 if executed
        drive(1'b1, 2'd0, 2'd0, 2'd0, 1'b0, 4'b0000, 1'b1, 1'b1, '0, 4'hC);
        step(); idle(); step();
        check("mem_r0", regflat[3:0], 4'hC);
        check("mem_status", status, 4'b0101);
        drive(1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 4'b1111, 1'b0, 1'b1, '0, 4'h3);
        step(); idle(); step();
        check("bubble_r0", regflat[3:0], 4'hC);
        check("bubble_status", status, 4'b0101);

        // increment wrap
        load(2'd1, 4'hF);
        step();
        drive(1'b1, 2'd2, 2'd1, 2'd0, 1'b0, 4'b0001, 1'b0, 1'b1, '0, '0);
        step();
        check("loadf_status", status, 4'b0010);
        idle(); step();
        check("wrap_r2", regflat[11:8], 4'h0);
        check("wrap_status", status, 4'b0101);

        // shift left with carry out of the MSB
        load(2'd1, 4'h9);
        step();
        drive(1'b1, 2'd3, 2'd0, 2'd1, 1'b0, 4'b1101, 1'b0, 1'b1, '0, '0);
        step(); idle(); step();
        check("shl_r3", regflat[15:12], 4'h2);
        check("shl_status", status, 4'b0100);

        // self-dependent chain: R1 = R1 + R1 twice
        load(2'd1, 4'h3);
        step();
        drive(1'b1, 2'd1, 2'd1, 2'd1, 1'b0, 4'b0010, 1'b0, 1'b1, '0, '0);
        step();
        drive(1'b1, 2'd1, 2'd1, 2'd1, 1'b0, 4'b0010, 1'b0, 1'b1, '0, '0);
        step(); idle(); step();
        check("chain_r1", regflat[7:4], 4'hC);
        check("chain_status", status, 4'b1010);

        // every function code, register B then constant B
        load(2'd1, 4'h6);
        step();
        load(2'd2, 4'hB);
        step();
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, 2'd3, 2'd1, 2'd2, 1'b0, 4'(k), 1'b0, 1'b1, '0, '0);
            step();
        end
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, 2'd3, 2'd2, 2'd1, 1'b1, 4'(k), 1'b0, 1'b1, 4'h8, '0);
            step();
        end
        idle(); step();

        // reset with a write to R1 in flight
        load(2'd1, 4'h5);
        step();
        drive(1'b1, 2'd2, 2'd1, 2'd1, 1'b0, 4'b0010, 1'b0, 1'b1, '0, '0);
        step(); idle(); step();
        check("prereset_status", status, 4'b1010);
        load(2'd1, 4'h7);
        step();
        idle();
        #2 rst = 1'b1;
        #1;
        check("midreset_regs", regflat, 16'h0);
        check("midreset_status", status, 4'h0);
        #3 rst = 1'b0;
        step(); step();
        check("postreset_r1", regflat[7:4], 4'h0);
        check("postreset_regs", regflat, 16'h0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
